wbc_intercon_param: RTL and testbench
=====================================

# wbc_intercon_param

Parametrised shared-bus WISHBONE interconnect: N masters, M slaves, address map supplied as parameter vectors. Registered round-robin arbitration holds the grant for an entire cycle; unmapped accesses and hung slaves are terminated with ERR; every bus fault is captured for debug. Sits between the register masters (BMC, SPI, PCIe) and the register/RAM slaves of the RADIANT core. It replaces fixed-map interconnects.

## Interface
- NUM_MASTERS, 3: master count, 1–8.
- NUM_SLAVES, 6: slave count, 1–16.
- ADR_W, 22: address width.
- DAT_W, 32: data width. SEL_W = DAT_W/8.
- SLAVE_BASE, 0: NUM_SLAVES*ADR_W vector; slice k is slave k's base.
- SLAVE_MASK, 0: NUM_SLAVES*ADR_W vector; slice k marks offset bits passed to slave k.
- TIMEOUT_CYCLES, 255: watchdog limit, ≥2. Used only with the timeout macro.

Ports:
- clk_i  in  1  bus clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- m_cyc_i, m_stb_i, m_we_i  in  NUM_MASTERS each  per-master controls.
- m_adr_i  in  NUM_MASTERS*ADR_W  master addresses.
- m_dat_i  in  NUM_MASTERS*DAT_W  master write data.
- m_sel_i  in  NUM_MASTERS*SEL_W  master byte selects.
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  terminations, only to the granted master.
- m_dat_o  out  DAT_W  read data, broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  NUM_SLAVES each  per-slave controls.
- s_adr_o  out  ADR_W  granted address AND the selected slave's mask.
- s_dat_o  out  DAT_W  granted write data.
- s_sel_o  out  SEL_W  granted byte selects.
- s_ack_i, s_err_i, s_rty_i  in  NUM_SLAVES each  slave terminations.
- s_dat_i  in  NUM_SLAVES*DAT_W  slave read data.
- gnt_o  out  NUM_MASTERS  registered one-hot grant.
- fault_o  out  1  one-cycle pulse per fault.
- fault_cause_o  out  2  01 = decode miss, 10 = timeout.
- fault_adr_o  out  ADR_W  full address of the faulting access.

## Operation
- Arbiter states: IDLE (gnt=0) and OWNED(k).
  - IDLE → OWNED(k) when any m_cyc_i is high. k is the first requester searching upward, with wrap, from last_owner+1.
  - OWNED(k) → IDLE when m_cyc_i[k] falls. A master is never preempted.
  - last_owner resets to NUM_MASTERS-1, so master 0 wins the first arbitration.
- Decode: slave k is hit when (adr & ~mask_k) == base_k. On overlapping maps the lowest index wins, and hits are one-hot.
- Slave controls: s_cyc_o[k] = cyc & hit_k; s_stb_o[k] and s_we_o[k] are formed the same way. All are 0 when idle.
- Return path: m_dat_o and the terminations come from the hit slave; 0 on a miss.
- Decode miss: granted stb with no hit drives m_err_o[k] combinationally while stb is high, and raises fault with cause 01.
- Fault capture: fault_adr_o and fault_cause_o load on the fault cycle and hold until the next fault.

## Timing
- Reset: every registered output is 0 (gnt_o, fault_o, fault_cause_o, fault_adr_o). Combinational outputs are therefore 0 as well.
- Grant latency: m_cyc_i rising in IDLE at edge n gives gnt_o at edge n+1, and slave cyc/stb in that same cycle.
- Re-arbitration: owner drops cyc at edge n → IDLE during n+1 → next owner granted at n+2. There is one dead cycle between owners, including back-to-back requests from the same master.
- Single-cycle termination paths are combinational: slave ack/err/rty → m_*_o, with zero added latency.
- Reset mid-cycle: the grant drops immediately and asynchronously. Any transfer in flight is abandoned without termination.

## Configuration
- WBC_INTERCON_TIMEOUT_EN defined:
  - A counter increments on each cycle with granted stb, a slave hit, and no slave ack/err/rty. It clears on any termination or when stb is low.
  - When it reaches TIMEOUT_CYCLES, m_err_o[k] pulses for one cycle. fault pulses with cause 10 and the counter clears.
  - If a slave termination arrives in the same cycle, the slave termination wins and no timeout is raised.
- WBC_INTERCON_TIMEOUT_EN undefined: no counter exists, a hung slave stalls the bus indefinitely, and cause 10 never occurs.

## Test plan
- Reset, then master 0 reads 0x010004 with slave 1 at base 0x010000, mask 0x00FFFF → s_adr_o=0x0004, s_cyc_o=6'b000010, gnt_o=001 one cycle after cyc; data 0xDEADBEEF returned on ack.
- Masters 0, 1 and 2 hold cyc continuously, each issuing single transfers → grant order 0,1,2,0, with exactly one idle cycle between owners.
- Master 1 accesses 0x3F0000 (unmapped) → m_err_o[1]=1 while stb is high; fault_o pulses; fault_cause_o=01, fault_adr_o=0x3F0000; no s_cyc_o asserted.
- With timeout enabled and TIMEOUT_CYCLES=8, slave 2 never acks → m_err_o pulses on the 8th stb cycle, cause=10. A slave ack that coincides with the 8th cycle instead gives an ack and no fault.
- rst_n_i asserted mid-transfer → gnt_o, s_cyc_o and fault_o are 0 immediately. After release, master 0 wins arbitration first.

Source files
------------

// File: rtl/wbc_intercon_param_if.sv
// Shared-bus WISHBONE interconnect signal bundle.
// Modport master: the interconnect's view of its masters
// (m_cyc/stb/we/adr/dat/sel in, m_ack/err/rty/dat out).
// Modport slave: the interconnect's view of its slaves
// (s_cyc/stb/we/adr/dat/sel out, s_ack/err/rty/dat in).
interface wbc_intercon_param_if #(
    parameter int NUM_MASTERS = 3,
    parameter int NUM_SLAVES  = 6,
    parameter int ADR_W       = 22,
    parameter int DAT_W       = 32
);
    localparam int SEL_W = DAT_W / 8;

    logic [NUM_MASTERS-1:0]       m_cyc_i;
    logic [NUM_MASTERS-1:0]       m_stb_i;
    logic [NUM_MASTERS-1:0]       m_we_i;
    logic [NUM_MASTERS*ADR_W-1:0] m_adr_i;
    logic [NUM_MASTERS*DAT_W-1:0] m_dat_i;
    logic [NUM_MASTERS*SEL_W-1:0] m_sel_i;
    logic [NUM_MASTERS-1:0]       m_ack_o;
    logic [NUM_MASTERS-1:0]       m_err_o;
    logic [NUM_MASTERS-1:0]       m_rty_o;
    logic [DAT_W-1:0]             m_dat_o;

    logic [NUM_SLAVES-1:0]        s_cyc_o;
    logic [NUM_SLAVES-1:0]        s_stb_o;
    logic [NUM_SLAVES-1:0]        s_we_o;
    logic [ADR_W-1:0]             s_adr_o;
    logic [DAT_W-1:0]             s_dat_o;
    logic [SEL_W-1:0]             s_sel_o;
    logic [NUM_SLAVES-1:0]        s_ack_i;
    logic [NUM_SLAVES-1:0]        s_err_i;
    logic [NUM_SLAVES-1:0]        s_rty_i;
    logic [NUM_SLAVES*DAT_W-1:0]  s_dat_i;

    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output m_ack_o, m_err_o, m_rty_o, m_dat_o
    );

    modport slave (
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_ack_i, s_err_i, s_rty_i, s_dat_i
    );
endinterface

// File: rtl/wbc_intercon_param.sv
// N-master / M-slave shared WISHBONE bus: registered round-robin grant
// held for a whole cycle, parameter address map, ERR on decode miss.
// Ports: clk_i, rst_n_i (async, active low), mb (master modport),
// sb (slave modport), gnt_o (one-hot grant), fault_o/fault_cause_o/
// fault_adr_o (fault pulse, 01 miss / 10 timeout, faulting address).
// Optional watchdog on hung slaves: define WBC_INTERCON_TIMEOUT_EN.
module wbc_intercon_param #(
    parameter int NUM_MASTERS    = 3,
    parameter int NUM_SLAVES     = 6,
    parameter int ADR_W          = 22,
    parameter int DAT_W          = 32,
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    wbc_intercon_param_if.master    mb,
    wbc_intercon_param_if.slave     sb,
    output logic [NUM_MASTERS-1:0]  gnt_o,
    output logic                    fault_o,
    output logic [1:0]              fault_cause_o,
    output logic [ADR_W-1:0]        fault_adr_o
);
    localparam int SEL_W = DAT_W / 8;
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 state_q;
    logic [MW-1:0]          own_q;
    logic [MW-1:0]          last_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [MW-1:0]          pick_d;
    logic                   pick_vld_d;
    int                     j;

    // First requester searching upward from last_owner+1, with wrap.
    always_comb begin
        pick_d     = last_q;
        pick_vld_d = 1'b0;
        j          = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            j = (int'(last_q) + i) % NUM_MASTERS;
            if (!pick_vld_d && mb.m_cyc_i[j[MW-1:0]]) begin
                pick_vld_d = 1'b1;
                pick_d     = j[MW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            own_q   <= '0;
            last_q  <= MW'(NUM_MASTERS - 1);
            gnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        state_q <= OWNED;
                        own_q   <= pick_d;
                        gnt_q   <= NUM_MASTERS'(1) << pick_d;
                    end
                end
                OWNED: begin
                    if (!mb.m_cyc_i[own_q]) begin
                        state_q <= IDLE;
                        last_q  <= own_q;
                        gnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic             g_cyc, g_stb, g_we;
    logic [ADR_W-1:0] g_adr;
    logic [DAT_W-1:0] g_dat;
    logic [SEL_W-1:0] g_sel;

    assign g_cyc = (state_q == OWNED) & mb.m_cyc_i[own_q];
    assign g_stb = g_cyc & mb.m_stb_i[own_q];
    assign g_we  = g_cyc & mb.m_we_i[own_q];
    assign g_adr = mb.m_adr_i[own_q*ADR_W +: ADR_W];
    assign g_dat = mb.m_dat_i[own_q*DAT_W +: DAT_W];
    assign g_sel = mb.m_sel_i[own_q*SEL_W +: SEL_W];

    logic [NUM_SLAVES-1:0] hit_d;
    logic [ADR_W-1:0]      hmask_d;
    logic [DAT_W-1:0]      hdat_d;

    // Scan downward so the lowest matching index is the one kept.
    always_comb begin
        hit_d   = '0;
        hmask_d = '0;
        hdat_d  = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (g_cyc &&
                (g_adr & ~SLAVE_MASK[k*ADR_W +: ADR_W]) ==
                SLAVE_BASE[k*ADR_W +: ADR_W]) begin
                hit_d    = '0;
                hit_d[k] = 1'b1;
                hmask_d  = SLAVE_MASK[k*ADR_W +: ADR_W];
                hdat_d   = sb.s_dat_i[k*DAT_W +: DAT_W];
            end
        end
    end

    logic hit_any, s_ack, s_err, s_rty, s_term, miss, tmo_hit;

    assign hit_any = |hit_d;
    assign s_ack   = g_stb & |(sb.s_ack_i & hit_d);
    assign s_err   = g_stb & |(sb.s_err_i & hit_d);
    assign s_rty   = g_stb & |(sb.s_rty_i & hit_d);
    assign s_term  = s_ack | s_err | s_rty;
    assign miss    = g_stb & ~hit_any;

`ifdef WBC_INTERCON_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_pend;

    // A coinciding slave termination suppresses the timeout.
    assign tmo_pend = g_stb & hit_any & ~s_term;
    assign tmo_hit  = tmo_pend &
                      (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
        end else if (!tmo_pend || tmo_hit) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    logic [TW-1:0] unused_tmo;

    assign unused_tmo = TW'(TIMEOUT_CYCLES);
    assign tmo_hit    = 1'b0;
`endif

    assign mb.m_ack_o = gnt_q & {NUM_MASTERS{s_ack}};
    assign mb.m_err_o = gnt_q & {NUM_MASTERS{s_err | miss | tmo_hit}};
    assign mb.m_rty_o = gnt_q & {NUM_MASTERS{s_rty}};
    assign mb.m_dat_o = hdat_d;

    assign sb.s_cyc_o = hit_d;
    assign sb.s_stb_o = hit_d & {NUM_SLAVES{g_stb}};
    assign sb.s_we_o  = hit_d & {NUM_SLAVES{g_we}};
    assign sb.s_adr_o = g_adr & hmask_d;
    assign sb.s_dat_o = g_cyc ? g_dat : '0;
    assign sb.s_sel_o = g_cyc ? g_sel : '0;

    logic             fault_q;
    logic [1:0]       cause_q;
    logic [ADR_W-1:0] fadr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fault_q <= 1'b0;
            cause_q <= 2'b00;
            fadr_q  <= '0;
        end else begin
            fault_q <= miss | tmo_hit;
            if (miss || tmo_hit) begin
                cause_q <= miss ? 2'b01 : 2'b10;
                fadr_q  <= g_adr;
            end
        end
    end

    assign gnt_o         = gnt_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign fault_adr_o   = fadr_q;
endmodule

// File: tb/tb_wbc_intercon_param.sv
// Scoreboard bench for wbc_intercon_param: 3 masters, 6 slaves
// (0-3 memories, 4 retries, 5 errors), slave k at k<<16, 64 KiB each.
module tb_wbc_intercon_param;
    localparam int NM = 3;
    localparam int NS = 6;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam logic [NS*AW-1:0] BASE = {22'h050000, 22'h040000,
        22'h030000, 22'h020000, 22'h010000, 22'h000000};
    localparam logic [NS*AW-1:0] MASK = {6{22'h00FFFF}};
    localparam logic [2:0] T_ACK = 3'b100;
    localparam logic [2:0] T_ERR = 3'b010;
    localparam logic [2:0] T_RTY = 3'b001;

    typedef struct {
        logic [2:0]  term;
        logic        rd;
        logic [31:0] dat;
    } exp_t;

    logic clk, rst_n;
    logic [NM-1:0] gnt;
    logic          fault;
    logic [1:0]    cause;
    logic [AW-1:0] fadr;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        exp_q [NM][$];
    int          gnt_log[$];
    logic [31:0] ref_mem[int];
    logic [31:0] smem[int];
    int          dly[NS];
    int          cnt[NS];
    bit          hang[NS];
    int          fdly = -1;

    wbc_intercon_param_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS),
        .ADR_W(AW), .DAT_W(DW)) ifc ();

    wbc_intercon_param #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADR_W(AW), .DAT_W(DW),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .mb(ifc), .sb(ifc),
        .gnt_o(gnt), .fault_o(fault), .fault_cause_o(cause),
        .fault_adr_o(fadr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    // Slave environment: memories with 0..2 cycles of wait state.
    always @(posedge clk) begin
        #2;
        for (int s = 0; s < NS; s++) begin
            ifc.s_ack_i[s] = 1'b0;
            ifc.s_err_i[s] = 1'b0;
            ifc.s_rty_i[s] = 1'b0;
            if (ifc.s_cyc_o[s] && ifc.s_stb_o[s] && !hang[s]) begin
                int a;
                logic [31:0] w;
                a = s * 65536 + int'(ifc.s_adr_o);
                w = smem.exists(a) ? smem[a] : 32'h0;
                ifc.s_dat_i[s*DW +: DW] = w;
                if (cnt[s] >= dly[s]) begin
                    cnt[s] = 0;
                    dly[s] = (fdly >= 0) ? fdly : int'($urandom_range(0, 2));
                    if (s == 4) ifc.s_rty_i[s] = 1'b1;
                    else if (s == 5) ifc.s_err_i[s] = 1'b1;
                    else begin
                        ifc.s_ack_i[s] = 1'b1;
                        if (ifc.s_we_o[s]) begin
                            for (int b = 0; b < 4; b++)
                                if (ifc.s_sel_o[b])
                                    w[8*b +: 8] = ifc.s_dat_o[8*b +: 8];
                            smem[a] = w;
                        end
                    end
                end else cnt[s]++;
            end else cnt[s] = 0;
        end
    end

    function automatic int rr_pick(input logic [NM-1:0] req, input int last);
        for (int i = 1; i <= NM; i++)
            if (req[(last + i) % NM]) return (last + i) % NM;
        return -1;
    endfunction

    // Monitor: termination scoreboard and arbitration reference model.
    logic [NM-1:0] pg, pc;
    int            last_own;
    always @(negedge clk) begin
        if (!rst_n) begin
            pg = '0;
            pc = '0;
            last_own = NM - 1;
        end else begin
            for (int k = 0; k < NM; k++) begin
                logic [2:0] t;
                t = {ifc.m_ack_o[k], ifc.m_err_o[k], ifc.m_rty_o[k]};
                if (t != 3'b000) begin
                    if (exp_q[k].size() == 0) begin
                        chk(1'b0, "unexpected_term", 64'(t), 64'h0);
                    end else begin
                        exp_t e;
                        e = exp_q[k].pop_front();
                        chk(t == e.term, $sformatf("term_m%0d", k),
                            64'(t), 64'(e.term));
                        if (e.rd && e.term == T_ACK)
                            chk(ifc.m_dat_o == e.dat, $sformatf("rdata_m%0d", k),
                                64'(ifc.m_dat_o), 64'(e.dat));
                    end
                end
            end
            chk(((ifc.m_ack_o | ifc.m_err_o | ifc.m_rty_o) & ~gnt) == 0,
                "term_to_ungranted", 64'(ifc.m_ack_o), 64'(gnt));
            chk($onehot0(ifc.s_cyc_o), "s_cyc_onehot",
                64'(ifc.s_cyc_o), 64'h0);
            if (pg == 0) begin
                if (pc != 0) begin
                    int p;
                    p = rr_pick(pc, last_own);
                    chk(gnt == NM'(1 << p), "arb_pick", 64'(gnt), 64'(1 << p));
                    gnt_log.push_back(p);
                end else begin
                    chk(gnt == 0, "idle_gnt", 64'(gnt), 64'h0);
                end
            end else if ((pc & pg) != 0) begin
                chk(gnt == pg, "gnt_hold", 64'(gnt), 64'(pg));
            end else begin
                chk(gnt == 0, "gnt_release", 64'(gnt), 64'h0);
                for (int k = 0; k < NM; k++) if (pg[k]) last_own = k;
            end
            pg = gnt;
            pc = ifc.m_cyc_i;
        end
    end

    task automatic xfer(input int k, input bit we, input logic [AW-1:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [2:0] force_term,
                        output int gw, output int tw,
                        output logic [NS-1:0] scyc, output logic [AW-1:0] sadr);
        exp_t e;
        int   sl;
        bit   done;
        sl = int'(adr[21:16]);
        e.rd = !we;
        e.dat = 32'h0;
        if (force_term != 3'b000) e.term = force_term;
        else if (sl >= 5) e.term = T_ERR;
        else if (sl == 4) e.term = T_RTY;
        else begin
            logic [31:0] w;
            e.term = T_ACK;
            w = ref_mem.exists(int'(adr)) ? ref_mem[int'(adr)] : 32'h0;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
                ref_mem[int'(adr)] = w;
            end
            e.dat = w;
        end
        exp_q[k].push_back(e);
        @(posedge clk);
        #1;
        ifc.m_cyc_i[k] = 1'b1;
        ifc.m_stb_i[k] = 1'b1;
        ifc.m_we_i[k]  = we;
        ifc.m_adr_i[k*AW +: AW] = adr;
        ifc.m_dat_i[k*DW +: DW] = dat;
        ifc.m_sel_i[k*4 +: 4]   = sel;
        gw = 0; tw = 0; done = 0; scyc = '0; sadr = '0;
        while (!done) begin
            @(negedge clk);
            if (gnt[k]) begin
                if (tw == 0) begin
                    scyc = ifc.s_cyc_o;
                    sadr = ifc.s_adr_o;
                end
                tw++;
                if (ifc.m_ack_o[k] || ifc.m_err_o[k] || ifc.m_rty_o[k])
                    done = 1;
            end else gw++;
            if (gw + tw > 1000) begin
                chk(1'b0, $sformatf("xfer_timeout_m%0d", k), 64'(gw + tw), 64'd0);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        ifc.m_cyc_i[k] = 1'b0;
        ifc.m_stb_i[k] = 1'b0;
    endtask

    task automatic rand_master(input int k, input int n);
        int gw, tw;
        logic [NS-1:0] sc;
        logic [AW-1:0] sa, adr;
        logic [5:0] up;
        logic [3:0] lo;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            up = ($urandom_range(0, 9) < 2) ? 6'($urandom_range(6, 63))
                                           : 6'($urandom_range(0, 5));
            lo = 4'($urandom);
            adr = {up, 8'h00, 2'(k), lo, 2'b00};
            xfer(k, 1'($urandom), adr, $urandom,
                 4'($urandom_range(1, 15)), 3'b000, gw, tw, sc, sa);
        end
    endtask

    task automatic one(input int k, input logic [AW-1:0] adr);
        int gw, tw;
        logic [NS-1:0] sc;
        logic [AW-1:0] sa;
        xfer(k, 1'b0, adr, 32'h0, 4'hF, 3'b000, gw, tw, sc, sa);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got %0d, want 0", 1);
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        int gw, tw, b;
        logic [NS-1:0] sc;
        logic [AW-1:0] sa;
        for (int s = 0; s < NS; s++) begin
            dly[s] = 0; cnt[s] = 0; hang[s] = 0;
        end
        rst_n = 1'b0;
        ifc.m_cyc_i = '1;
        ifc.m_stb_i = '1;
        ifc.m_we_i  = '0;
        ifc.m_adr_i = {NM{22'h010000}};
        ifc.m_dat_i = '0;
        ifc.m_sel_i = '1;
        repeat (3) @(negedge clk);
        chk(gnt == 0, "rst_gnt", 64'(gnt), 64'h0);
        chk(fault == 0, "rst_fault", 64'(fault), 64'h0);
        chk(cause == 0, "rst_cause", 64'(cause), 64'h0);
        chk(fadr == 0, "rst_fadr", 64'(fadr), 64'h0);
        chk(ifc.s_cyc_o == 0, "rst_s_cyc", 64'(ifc.s_cyc_o), 64'h0);
        chk(ifc.s_adr_o == 0, "rst_s_adr", 64'(ifc.s_adr_o), 64'h0);
        chk(ifc.m_ack_o == 0, "rst_m_ack", 64'(ifc.m_ack_o), 64'h0);
        ifc.m_cyc_i = '0;
        ifc.m_stb_i = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Round robin from reset: 0,1,2 then master 0 again.
        b = gnt_log.size();
        fork
            begin one(0, 22'h000010); one(0, 22'h000014); end
            one(1, 22'h010040);
            one(2, 22'h020080);
        join
        chk(gnt_log.size() - b == 4, "rr_count", 64'(gnt_log.size() - b), 64'd4);
        if (gnt_log.size() - b == 4) begin
            chk(gnt_log[b] == 0, "rr_0", 64'(gnt_log[b]), 64'd0);
            chk(gnt_log[b+1] == 1, "rr_1", 64'(gnt_log[b+1]), 64'd1);
            chk(gnt_log[b+2] == 2, "rr_2", 64'(gnt_log[b+2]), 64'd2);
            chk(gnt_log[b+3] == 0, "rr_3", 64'(gnt_log[b+3]), 64'd0);
        end

        // Read through slave 1 with its offset-only address.
        ref_mem[32'h010004] = 32'hDEADBEEF;
        smem[1*65536 + 4]   = 32'hDEADBEEF;
        xfer(0, 1'b0, 22'h010004, 32'h0, 4'hF, 3'b000, gw, tw, sc, sa);
        chk(gw == 1, "grant_latency", 64'(gw), 64'd1);
        chk(sc == 6'b000010, "decode_s_cyc", 64'(sc), 64'h2);
        chk(sa == 22'h0004, "decode_s_adr", 64'(sa), 64'h4);

        // Unmapped access terminates with ERR and records the fault.
        xfer(1, 1'b0, 22'h3F0000, 32'h0, 4'hF, 3'b000, gw, tw, sc, sa);
        chk(sc == 0, "miss_s_cyc", 64'(sc), 64'h0);
        @(negedge clk);
        chk(fault == 1, "miss_fault", 64'(fault), 64'h1);
        chk(cause == 2'b01, "miss_cause", 64'(cause), 64'h1);
        chk(fadr == 22'h3F0000, "miss_fadr", 64'(fadr), 64'h3F0000);
        @(negedge clk);
        chk(fault == 0, "miss_pulse", 64'(fault), 64'h0);
        chk(cause == 2'b01, "miss_cause_hold", 64'(cause), 64'h1);

`ifdef WBC_INTERCON_TIMEOUT_EN
        hang[2] = 1;
        xfer(0, 1'b0, 22'h020008, 32'h0, 4'hF, T_ERR, gw, tw, sc, sa);
        chk(tw == 8, "tmo_cycles", 64'(tw), 64'd8);
        @(negedge clk);
        chk(fault == 1, "tmo_fault", 64'(fault), 64'h1);
        chk(cause == 2'b10, "tmo_cause", 64'(cause), 64'h2);
        chk(fadr == 22'h020008, "tmo_fadr", 64'(fadr), 64'h020008);
        hang[2] = 0;
        fdly = 7;
        dly[2] = 7;
        xfer(0, 1'b0, 22'h02000C, 32'h0, 4'hF, 3'b000, gw, tw, sc, sa);
        chk(tw == 8, "late_ack_cycles", 64'(tw), 64'd8);
        @(negedge clk);
        chk(fault == 0, "late_ack_nofault", 64'(fault), 64'h0);
        fdly = -1;
        dly[2] = 0;
`endif

        fork
            rand_master(0, 25);
            rand_master(1, 25);
            rand_master(2, 25);
        join

        // Reset while a transfer to a stalled slave is in flight.
        hang[3] = 1;
        @(posedge clk);
        #1;
        ifc.m_cyc_i[0] = 1'b1;
        ifc.m_stb_i[0] = 1'b1;
        ifc.m_we_i[0]  = 1'b0;
        ifc.m_adr_i[0 +: AW] = 22'h030000;
        repeat (3) @(negedge clk);
        chk(gnt == 3'b001, "inflight_gnt", 64'(gnt), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk(gnt == 0, "async_rst_gnt", 64'(gnt), 64'h0);
        chk(ifc.s_cyc_o == 0, "async_rst_s_cyc", 64'(ifc.s_cyc_o), 64'h0);
        chk(fault == 0, "async_rst_fault", 64'(fault), 64'h0);
        ifc.m_cyc_i[0] = 1'b0;
        ifc.m_stb_i[0] = 1'b0;
        hang[3] = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        b = gnt_log.size();
        fork
            one(2, 22'h000084);
            one(0, 22'h000004);
        join
        chk(gnt_log.size() - b == 2, "post_rst_count",
            64'(gnt_log.size() - b), 64'd2);
        if (gnt_log.size() - b == 2)
            chk(gnt_log[b] == 0, "post_rst_first", 64'(gnt_log[b]), 64'd0);

        repeat (4) @(negedge clk);
        for (int k = 0; k < NM; k++)
            chk(exp_q[k].size() == 0, $sformatf("drain_m%0d", k),
                64'(exp_q[k].size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
